// File: rtl/burst_pkg.sv
// Shared types and latency helper for the burst scheduler and buffer users.
package burst_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_FILL      = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_PRESENT   = 3'd4
  } sched_state_t;

  // ce cycles the buffer needs after clr before it reports burst_complete
  function automatic int fill_len(input int initial_latency, input int m);
    return initial_latency + m + 2;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_i and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int   cand_s;
  logic found_s;

  // first requester at or after last_i+1 (mod N) wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int i = 1; i <= N; i++) begin
      cand_s = int'(last_i) + i;
      cand_s = (cand_s >= N) ? (cand_s - N) : cand_s;
      if (!found_s && req_i[cand_s]) begin
        grant_o[cand_s] = 1'b1;
        idx_o           = IW'(cand_s);
        found_s         = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/burst_sched.sv
// Round-robin scheduler that owns a shared burst_buffer's clr/ce and runs
// clear -> fill -> confirm -> present for each granted requester.
module burst_sched
  import burst_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int INITIAL_LATENCY = 3,
  parameter int M               = 5,
  parameter int DONE_TIMEOUT    = 4
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     stall,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     bb_clr,
  output logic                     bb_ce,
  input  logic                     bb_burst_complete,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     err_timeout
);

  localparam int FILL_LEN = fill_len(INITIAL_LATENCY, M);
  localparam int IW       = $clog2(N_REQ);
  localparam int CW       = $clog2(FILL_LEN + 1);
  localparam int WW       = $clog2(DONE_TIMEOUT + 1);

  sched_state_t   state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]  grant_id_q, grant_id_d;
  logic [IW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic           err_q, err_d;

  logic [N_REQ-1:0] arb_grant_s;
  logic [IW-1:0]    arb_idx_s;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s)
  );

  // state register; reset leaves last_q at N_REQ-1 so requester 0 wins first
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= IW'(N_REQ - 1);
      cnt_q      <= '0;
      wait_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
    end
  end

  // next-state and buffer control decode
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    err_d      = err_q;
    bb_clr     = 1'b0;
    bb_ce      = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_d    = arb_grant_s;
          grant_id_d = arb_idx_s;
          state_d    = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        bb_clr  = 1'b1;
        cnt_d   = '0;
        state_d = S_FILL;
      end
      S_FILL: begin
        bb_ce = ~stall;
        if (!stall) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(FILL_LEN - 1)) begin
            wait_d  = '0;
            state_d = S_WAIT_DONE;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_WAIT_DONE: begin
        if (bb_burst_complete) begin
          state_d = S_PRESENT;
        end else if (wait_q == WW'(DONE_TIMEOUT - 1)) begin
          // give up on this burst but still rotate priority past it
          err_d      = 1'b1;
          grant_d    = '0;
          grant_id_d = '0;
          last_d     = grant_id_q;
          state_d    = S_IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          grant_d    = '0;
          grant_id_d = '0;
          last_d     = grant_id_q;
          state_d    = S_IDLE;
        end else begin
          state_d = S_PRESENT;
        end
      end
      default: begin
        grant_d    = '0;
        grant_id_d = '0;
        state_d    = S_IDLE;
      end
    endcase
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_burst_sched.sv
// Self-checking bench for burst_sched with a behavioural buffer and a
// timeline/round-robin reference model.
module tb_burst_sched;

  localparam int NR       = 4;
  localparam int IL       = 3;
  localparam int MM       = 5;
  localparam int DTO      = 4;
  localparam int FILL_LEN = IL + MM + 2;

  logic          clk = 1'b0;
  logic          clr_n;
  logic [NR-1:0] req;
  logic          stall;
  logic [NR-1:0] grant;
  logic [1:0]    grant_id;
  logic          bb_clr, bb_ce, bb_burst_complete;
  logic          out_valid, out_ready, busy, err_timeout;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int ptr_m = NR - 1;
  bit err_m = 1'b0;
  bit tie_done = 1'b1;
  int bb_cnt = 0;
  int t0, t1;

  burst_sched #(.N_REQ(NR), .INITIAL_LATENCY(IL), .M(MM), .DONE_TIMEOUT(DTO)) dut (
    .clk               (clk),
    .clr_n             (clr_n),
    .req               (req),
    .stall             (stall),
    .grant             (grant),
    .grant_id          (grant_id),
    .bb_clr            (bb_clr),
    .bb_ce             (bb_ce),
    .bb_burst_complete (bb_burst_complete),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .err_timeout       (err_timeout)
  );

  always #5 clk = ~clk;

  // buffer stand-in: completes once FILL_LEN ce pulses followed a clr
  always @(posedge clk) begin
    if (bb_clr) bb_cnt <= 0;
    else if (bb_ce) bb_cnt <= bb_cnt + 1;
  end
  assign bb_burst_complete = tie_done && (bb_cnt >= FILL_LEN);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    cyc_n++;
  endtask

  function automatic int pick(input logic [NR-1:0] r, input int p);
    for (int i = 1; i <= NR; i++) begin
      if (r[(p + i) % NR]) return (p + i) % NR;
    end
    return -1;
  endfunction

  // smode: 0 no stall, 1 random stalls, 2 three stalls after the 4th ce
  task automatic run_burst(input logic [NR-1:0] r, input bit hold, input int smode,
                           input int rdy_delay, input bit done_ok, output int t_idle);
    int w, ce_n, stalls, guard;
    logic [NR-1:0] g_exp;
    w = pick(r, ptr_m);
    g_exp = NR'(1 << w);
    t_idle = cyc_n;
    req = r; stall = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
    #2;
    chk("idle_busy", busy, 0); chk("idle_grant", grant, 0); chk("idle_ce", bb_ce, 0);
    tick();
    req = hold ? r : NR'($urandom); stall = 1'($urandom_range(0, 1));
    #2;
    chk("clr_grant", grant, g_exp); chk("clr_grant_id", grant_id, w);
    chk("clr_pulse", bb_clr, 1); chk("clr_ce", bb_ce, 0); chk("clr_busy", busy, 1);
    tick();
    ce_n = 0; stalls = 0; guard = 0;
    while (ce_n < FILL_LEN && guard < 100) begin
      case (smode)
        1: stall = ($urandom_range(0, 2) == 0);
        2: stall = (ce_n == 4 && stalls < 3);
        default: stall = 1'b0;
      endcase
      #2;
      chk("fill_ce", bb_ce, !stall); chk("fill_clr", bb_clr, 0);
      chk("fill_grant", grant, g_exp); chk("fill_valid", out_valid, 0);
      if (stall) stalls++; else ce_n++;
      guard++;
      tick();
    end
    chk("fill_bound", ce_n, FILL_LEN);
    stall = 1'($urandom_range(0, 1));
    #2;
    chk("wait_ce", bb_ce, 0); chk("wait_valid", out_valid, 0); chk("wait_busy", busy, 1);
    if (done_ok) begin
      tick();
      chk("valid_time", cyc_n - t_idle, FILL_LEN + 3 + stalls);
      for (int j = 0; j < rdy_delay; j++) begin
        out_ready = 1'b0; stall = 1'($urandom_range(0, 1));
        #2;
        chk("bp_valid", out_valid, 1); chk("bp_ce", bb_ce, 0); chk("bp_grant", grant, g_exp);
        tick();
      end
      out_ready = 1'b1; stall = 1'($urandom_range(0, 1));
      #2;
      chk("pres_valid", out_valid, 1); chk("pres_grant_id", grant_id, w);
      tick();
    end else begin
      for (int j = 1; j < DTO; j++) begin
        tick();
        stall = 1'($urandom_range(0, 1));
        #2;
        chk("to_busy", busy, 1); chk("to_err", err_timeout, err_m); chk("to_ce", bb_ce, 0);
      end
      tick();
      err_m = 1'b1;
    end
    ptr_m = w;
    chk("end_busy", busy, 0); chk("end_grant", grant, 0);
    chk("end_valid", out_valid, 0); chk("end_err", err_timeout, err_m);
  endtask

  initial begin
    clr_n = 1'b0; req = '0; stall = 1'b0; out_ready = 1'b1;
    #3;
    chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_clr", bb_clr, 0);
    chk("rst_ce", bb_ce, 0); chk("rst_valid", out_valid, 0); chk("rst_err", err_timeout, 0);
    #19 clr_n = 1'b1;
    tick();

    // single request
    run_burst(4'b0001, 1'b0, 0, 0, 1'b1, t0);

    // contention: all requesting, fixed 14-cycle period
    run_burst(4'b1111, 1'b1, 0, 0, 1'b1, t0);
    for (int k = 0; k < 4; k++) begin
      run_burst(4'b1111, 1'b1, 0, 0, 1'b1, t1);
      chk("rr_period", t1 - t0, FILL_LEN + 4);
      t0 = t1;
    end

    // stall mid-fill, then backpressure
    run_burst(4'b0010, 1'b0, 2, 0, 1'b1, t0);
    run_burst(4'b1000, 1'b0, 0, 5, 1'b1, t0);

    // randomized bursts
    for (int k = 0; k < 8; k++) begin
      run_burst(NR'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                $urandom_range(0, 4), 1'b1, t0);
    end

    // timeout, then next grant goes to the following requester
    tie_done = 1'b0;
    run_burst(4'b1111, 1'b0, 0, 0, 1'b0, t0);
    tie_done = 1'b1;
    run_burst(4'b1111, 1'b0, 0, 0, 1'b1, t0);

    // async reset in the middle of FILL
    req = 4'b0001; stall = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre_rst_ce", bb_ce, 1);
    #1 clr_n = 1'b0;
    #1;
    chk("arst_grant", grant, 0); chk("arst_grant_id", grant_id, 0); chk("arst_clr", bb_clr, 0);
    chk("arst_ce", bb_ce, 0); chk("arst_valid", out_valid, 0); chk("arst_busy", busy, 0);
    chk("arst_err", err_timeout, 0);
    ptr_m = NR - 1; err_m = 1'b0; req = '0;
    #2 clr_n = 1'b1;
    tick();
    run_burst(4'b0100, 1'b0, 0, 0, 1'b1, t0);
    run_burst(4'b0101, 1'b0, 1, 2, 1'b1, t0);
    req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
